// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
package sram_ctrl_pkg;

  // Access sequencing: idle, low half-word phase, high half-word phase, completion
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Phase counter width and the largest phase length it can time
  localparam int CNT_W = 4;
  localparam int MAX_ACCESS_CYCLES = 15;

  // CPU byte address that lands on SRAM word 0 unless overridden
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Value loaded into the down-counter so that it reaches zero on the last phase cycle
  function automatic logic [CNT_W-1:0] phaseLoadValue(input int accessCycles);
    return CNT_W'(accessCycles - 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side (MEM stage) request/response bundle for sram_ctrl.
// master = pipeline side issuing loads/stores, slave = the controller.
interface sram_ctrl_if;

  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en,
    output rd_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );

endinterface

// File: rtl/sram_ctrl_phase_timer.sv
// Loadable down-counter that flags the final cycle of a half-word phase.
module sram_phase_timer
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadValue_i,
  input  logic             en_i,
  output logic             phaseDone_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Reload for the next phase takes priority; otherwise count down while a phase runs
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign phaseDone_o = en_i && (count_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle MEM-stage controller for a 16-bit asynchronous SRAM.
// Each 32-bit word is moved as two half-words (low, then high), each phase
// lasting ACCESS_CYCLES clocks. ready drops while an access is in flight so
// the hazard logic freezes the pipeline, which keeps the request stable.
// Optional feature macro: SRAM_CTRL_READ_CACHE_EN adds a one-entry read cache.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int          SRAM_ADDR_W   = 18,
  parameter int          ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_ctrl_if.slave             bus,
  inout  wire  [15:0]            SRAM_DQ_io,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR_o,
  output logic                   SRAM_WE_N_o,
  output logic                   SRAM_OE_N_o,
  output logic                   SRAM_CE_N_o,
  output logic                   SRAM_UB_N_o,
  output logic                   SRAM_LB_N_o
);

  if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > MAX_ACCESS_CYCLES)) begin : gBadAccessCycles
    $error("sram_ctrl: ACCESS_CYCLES must lie in 1..15");
  end

  localparam logic [CNT_W-1:0] PHASE_LOAD = phaseLoadValue(ACCESS_CYCLES);

  state_e state_q, state_d;

  logic                   request;
  logic                   isWrite;
  logic                   isRead;
  logic                   startAccess;
  logic                   cacheHit;
  logic [31:0]            hitData;
  logic [31:0]            offset;
  logic [SRAM_ADDR_W-2:0] wordIdx;
  logic                   unusedOffsetBits;

  logic                   phaseDone;
  logic                   timerLoad;
  logic                   timerEn;

  logic                   ceN;
  logic                   weN;
  logic                   oeN;
  logic                   dqDrive;
  logic [15:0]            dqOut;
  logic                   highHalf;

  logic [15:0]            loHalf_q, loHalf_d;
  logic [31:0]            readData_q, readData_d;

  // A simultaneous load and store is handled as a store only
  assign request = bus.rd_en | bus.wr_en;
  assign isWrite = bus.wr_en;
  assign isRead  = bus.rd_en & ~bus.wr_en;

  // Byte address to SRAM word index; upper bits beyond the SRAM size wrap around
  assign offset           = bus.address - BASE_ADDR;
  assign wordIdx          = offset[SRAM_ADDR_W:2];
  assign unusedOffsetBits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  assign startAccess = (state_q == IDLE) && request && !cacheHit;
  assign timerEn     = (state_q == LO) || (state_q == HI);

  sram_phase_timer uPhaseTimer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (timerLoad),
    .loadValue_i (PHASE_LOAD),
    .en_i        (timerEn),
    .phaseDone_o (phaseDone)
  );

  // State register; reset abandons any access in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: each half-word phase ends when the timer expires, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startAccess) state_d = LO;
      LO:      if (phaseDone)   state_d = HI;
      HI:      if (phaseDone)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM strobes, data drive and timer reload decoded from the current state
  always_comb begin
    ceN       = 1'b1;
    weN       = 1'b1;
    oeN       = 1'b1;
    dqDrive   = 1'b0;
    dqOut     = bus.write_data[15:0];
    highHalf  = 1'b0;
    timerLoad = 1'b0;
    case (state_q)
      IDLE: begin
        timerLoad = startAccess;
      end
      LO: begin
        ceN       = 1'b0;
        weN       = ~isWrite;
        oeN       = ~isRead;
        dqDrive   = isWrite;
        timerLoad = phaseDone;
      end
      HI: begin
        ceN      = 1'b0;
        weN      = ~isWrite;
        oeN      = ~isRead;
        dqDrive  = isWrite;
        dqOut    = bus.write_data[31:16];
        highHalf = 1'b1;
      end
      default: begin
        ceN = 1'b1;
      end
    endcase
  end

  assign SRAM_ADDR_o = {wordIdx, highHalf};
  assign SRAM_CE_N_o = ceN;
  assign SRAM_UB_N_o = ceN;
  assign SRAM_LB_N_o = ceN;
  assign SRAM_WE_N_o = weN;
  assign SRAM_OE_N_o = oeN;
  assign SRAM_DQ_io  = dqDrive ? dqOut : 16'hzzzz;

  // Low half is parked until the high half arrives so read_data only changes on completion
  always_comb begin
    loHalf_d   = loHalf_q;
    readData_d = readData_q;
    if (cacheHit) begin
      readData_d = hitData;
    end
    if (isRead && phaseDone) begin
      if (state_q == LO) begin
        loHalf_d = SRAM_DQ_io;
      end
      if (state_q == HI) begin
        readData_d = {SRAM_DQ_io, loHalf_q};
      end
    end
  end

  // Read data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loHalf_q   <= '0;
      readData_q <= '0;
    end else begin
      loHalf_q   <= loHalf_d;
      readData_q <= readData_d;
    end
  end

`ifdef SRAM_CTRL_READ_CACHE_EN
  logic        cacheValid_q, cacheValid_d;
  logic [31:0] cacheTag_q, cacheTag_d;
  logic [31:0] cacheData_q, cacheData_d;

  assign cacheHit = (state_q == IDLE) && isRead && cacheValid_q && (cacheTag_q == bus.address);
  assign hitData  = cacheData_q;

  // Completed reads fill the entry; completed stores to the cached address keep it coherent
  always_comb begin
    cacheValid_d = cacheValid_q;
    cacheTag_d   = cacheTag_q;
    cacheData_d  = cacheData_q;
    if ((state_q == HI) && phaseDone) begin
      if (isRead) begin
        cacheValid_d = 1'b1;
        cacheTag_d   = bus.address;
        cacheData_d  = {SRAM_DQ_io, loHalf_q};
      end else if (isWrite && cacheValid_q && (cacheTag_q == bus.address)) begin
        cacheData_d = bus.write_data;
      end
    end
  end

  // Cache entry registers; reset invalidates the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cacheValid_q <= 1'b0;
      cacheTag_q   <= '0;
      cacheData_q  <= '0;
    end else begin
      cacheValid_q <= cacheValid_d;
      cacheTag_q   <= cacheTag_d;
      cacheData_q  <= cacheData_d;
    end
  end

  assign bus.read_data = cacheHit ? cacheData_q : readData_q;
`else
  assign cacheHit      = 1'b0;
  assign hitData       = '0;
  assign bus.read_data = readData_q;
`endif

  // Freeze the pipeline while a request is outstanding; held high during reset
  assign bus.ready = ~rst_n | cacheHit | ~(request & (state_q != DONE));

endmodule
